// File: rtl/coincidence_gated_counter.sv
// Pairwise coincidence counter: per-channel delay, window stretch and saturating
// pair counters accumulated over a timed acquisition gate with snapshot readout.
module coincidence_gated_counter #(
    parameter int NCHAN = 6,
    parameter int NBITS = 4,
    parameter int CBITS = 16,
    parameter int WBITS = 3,
    parameter int GBITS = 24
) (
    input  logic                                         Clk,
    input  logic                                         Rst_n,
    input  logic [NCHAN-1:0]                             Channels,
    input  logic [NCHAN-1:0][NBITS-1:0]                  Delays,
    input  logic [WBITS-1:0]                             Window,
    input  logic [GBITS-1:0]                             GateLen,
    input  logic                                         Start,
    input  logic                                         Abort,
    input  logic                                         Ack,
    output logic [NCHAN*(NCHAN-1)/2-1:0][CBITS-1:0]      Counts,
    output logic [NCHAN*(NCHAN-1)/2-1:0]                 Overflow,
    output logic                                         Valid,
    output logic                                         Busy
);

    localparam int NPAIR = NCHAN * (NCHAN - 1) / 2;
    localparam int DMAX  = (1 << NBITS) - 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                          state_q, state_d;
    logic [NCHAN-1:0]                prev_q, prev_d;
    logic [NCHAN-1:0]                edge_q, edge_d;
    logic [NCHAN-1:0][DMAX-1:0]      dline_q, dline_d;
    logic [NCHAN-1:0][WBITS-1:0]     str_q, str_d;
    logic [NCHAN-1:0][NBITS-1:0]     dly_q, dly_d;
    logic [WBITS-1:0]                win_q, win_d;
    logic [GBITS-1:0]                gate_q, gate_d;
    logic [NPAIR-1:0][CBITS-1:0]     cnt_q, cnt_d;
    logic [NPAIR-1:0]                ovf_q, ovf_d;
    logic [NPAIR-1:0][CBITS-1:0]     counts_q, counts_d;
    logic [NPAIR-1:0]                ovf_snap_q, ovf_snap_d;
    logic                            valid_q, valid_d;

    logic [NCHAN-1:0]                de;
    logic [NCHAN-1:0]                s;
    logic [NPAIR-1:0]                p;
    logic                            launch;

    // Front end: edge detect, delay tap select, window stretch, pair events.
    always_comb begin : front_end
        int k;
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        prev_d  = Channels;
        edge_d  = Channels & ~prev_q;
        dline_d = dline_q;
        str_d   = str_q;
        de      = '0;
        s       = '0;
        p       = '0;
        for (int c = 0; c < NCHAN; c++) begin
            dline_d[c][0] = edge_q[c];
            for (int t = 1; t < DMAX; t++) begin
                dline_d[c][t] = dline_q[c][t-1];
            end
            de[c] = (dly_q[c] == '0) ? edge_q[c] : dline_q[c][dly_q[c] - NBITS'(1)];
            s[c]  = de[c] | (str_q[c] != '0);
            if (de[c]) begin
                str_d[c] = win_q;
            end else if (str_q[c] != '0) begin
                str_d[c] = str_q[c] - WBITS'(1);
            end
        end
        k = 0;
        for (int i = 0; i < NCHAN - 1; i++) begin
            for (int j = i + 1; j < NCHAN; j++) begin
                p[k] = (de[i] & s[j]) | (de[j] & s[i]);
                k++;
            end
        end
    end

    // Abort outranks Start; Start is ignored while an acquisition runs.
    assign launch = Start && !Abort && (state_q != RUN);

    always_comb begin : control
        state_d    = state_q;
        dly_d      = dly_q;
        win_d      = win_q;
        gate_d     = gate_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        counts_d   = counts_q;
        ovf_snap_d = ovf_snap_q;
        valid_d    = valid_q;
        case (state_q)
            IDLE: ;
            RUN: begin
                for (int k = 0; k < NPAIR; k++) begin
                    if (p[k]) begin
                        if (cnt_q[k] == '1) ovf_d[k] = 1'b1;
                        else                cnt_d[k] = cnt_q[k] + CBITS'(1);
                    end
                end
                gate_d = gate_q - GBITS'(1);
                if (Abort) begin
                    state_d = IDLE;
                end else if (gate_q == GBITS'(1)) begin
                    state_d    = DONE;
                    counts_d   = cnt_d;
                    ovf_snap_d = ovf_d;
                    valid_d    = 1'b1;
                end
            end
            DONE: begin
                if (Abort || Ack) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (launch) begin
            state_d = RUN;
            valid_d = 1'b0;
            dly_d   = Delays;
            win_d   = Window;
            gate_d  = (GateLen == '0) ? GBITS'(1) : GateLen;
            cnt_d   = '0;
            ovf_d   = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= IDLE;
            prev_q     <= '0;
            edge_q     <= '0;
            // NOTE: the delay lines are reset so stale edges cannot leak into the first run.
            dline_q    <= '0;
            str_q      <= '0;
            dly_q      <= '0;
            win_q      <= '0;
            gate_q     <= '0;
            cnt_q      <= '0;
            ovf_q      <= '0;
            counts_q   <= '0;
            ovf_snap_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            edge_q     <= edge_d;
            dline_q    <= dline_d;
            str_q      <= str_d;
            dly_q      <= dly_d;
            win_q      <= win_d;
            gate_q     <= gate_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            counts_q   <= counts_d;
            ovf_snap_q <= ovf_snap_d;
            valid_q    <= valid_d;
        end
    end

    assign Counts   = counts_q;
    assign Overflow = ovf_snap_q;
    assign Valid    = valid_q;
    assign Busy     = (state_q == RUN);

endmodule

// File: tb/tb_coincidence_gated_counter.sv
// Scoreboard bench for coincidence_gated_counter with NCHAN=3 and CBITS=4.
module tb_coincidence_gated_counter;

    localparam int NCHAN = 3;
    localparam int NBITS = 4;
    localparam int CBITS = 4;
    localparam int WBITS = 3;
    localparam int GBITS = 8;
    localparam int NPAIR = 3;

    logic                             Clk;
    logic                             Rst_n;
    logic [NCHAN-1:0]                 Channels;
    logic [NCHAN-1:0][NBITS-1:0]      Delays;
    logic [WBITS-1:0]                 Window;
    logic [GBITS-1:0]                 GateLen;
    logic                             Start;
    logic                             Abort;
    logic                             Ack;
    logic [NPAIR-1:0][CBITS-1:0]      Counts;
    logic [NPAIR-1:0]                 Overflow;
    logic                             Valid;
    logic                             Busy;

    coincidence_gated_counter #(
        .NCHAN(NCHAN), .NBITS(NBITS), .CBITS(CBITS), .WBITS(WBITS), .GBITS(GBITS)
    ) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Channels(Channels), .Delays(Delays),
        .Window(Window), .GateLen(GateLen), .Start(Start), .Abort(Abort),
        .Ack(Ack), .Counts(Counts), .Overflow(Overflow), .Valid(Valid), .Busy(Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [11:0] counts;
        logic [2:0]  ovf;
        int          lat;
    } exp_t;

    exp_t             sb_q[$];
    logic [2:0]       stim_q[$];
    int               n_tests = 0;
    int               n_fail  = 0;
    int               run_cycles;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) stim_q.push_back(3'b000);
    endtask

    task automatic add_word(input logic [2:0] w);
        stim_q.push_back(w);
    endtask

    // Starts a run, scrambles the shadowed inputs, then plays the queued channel pattern.
    task automatic launch(input logic [11:0] dly, input int w, input int g,
                          input logic [11:0] exp_counts, input logic [2:0] exp_ovf);
        exp_t e;
        e.counts = exp_counts;
        e.ovf    = exp_ovf;
        e.lat    = (g == 0) ? 1 : g;
        sb_q.push_back(e);
        Delays  = dly;
        Window  = WBITS'(w);
        GateLen = GBITS'(g);
        Start   = 1'b1;
        tick();
        Start   = 1'b0;
        check("busy_after_start", 32'(Busy), 32'd1);
        check("valid_after_start", 32'(Valid), 32'd0);
        Delays  = 12'($urandom);
        Window  = WBITS'($urandom);
        GateLen = GBITS'($urandom);
        run_cycles = 0;
        foreach (stim_q[m]) begin
            Channels = stim_q[m];
            tick();
            run_cycles++;
        end
        Channels = '0;
        stim_q.delete();
    endtask

    task automatic collect(input string tag);
        exp_t e;
        while (!Valid && run_cycles < 300) begin
            tick();
            run_cycles++;
        end
        check({tag, "_valid"}, 32'(Valid), 32'd1);
        e = sb_q.pop_front();
        check({tag, "_latency"}, 32'(run_cycles), 32'(e.lat));
        check({tag, "_counts"}, 32'(Counts), 32'(e.counts));
        check({tag, "_overflow"}, 32'(Overflow), 32'(e.ovf));
        check({tag, "_busy_done"}, 32'(Busy), 32'd0);
    endtask

    task automatic do_ack(input string tag);
        Ack = 1'b1;
        tick();
        Ack = 1'b0;
        check({tag, "_valid_after_ack"}, 32'(Valid), 32'd0);
    endtask

    initial begin
        Rst_n    = 1'b0;
        Channels = '0;
        Delays   = '0;
        Window   = '0;
        GateLen  = '0;
        Start    = 1'b0;
        Abort    = 1'b0;
        Ack      = 1'b0;
        repeat (3) tick();
        check("rst_counts", 32'(Counts), 32'd0);
        check("rst_overflow", 32'(Overflow), 32'd0);
        check("rst_valid", 32'(Valid), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        Rst_n = 1'b1;
        repeat (2) tick();

        // Simultaneous ch0/ch1 rise.
        add_idle(4); add_word(3'b011);
        launch(12'h000, 0, 20, 12'h001, 3'b000);
        collect("same_cycle");
        do_ack("same_cycle");

        // Window 2: distance 2 counts, distance 3 does not.
        add_idle(3); add_word(3'b001); add_idle(1); add_word(3'b100);
        launch(12'h000, 2, 20, 12'h010, 3'b000);
        collect("win_in");
        do_ack("win_in");
        add_idle(3); add_word(3'b001); add_idle(2); add_word(3'b100);
        launch(12'h000, 2, 20, 12'h000, 3'b000);
        collect("win_out");
        do_ack("win_out");

        // Delay on ch1 realigns an early ch1 edge with ch0.
        add_idle(2); add_word(3'b010); add_idle(2); add_word(3'b001);
        launch(12'h030, 0, 20, 12'h001, 3'b000);
        collect("delay_on");
        do_ack("delay_on");
        add_idle(2); add_word(3'b010); add_idle(2); add_word(3'b001);
        launch(12'h000, 0, 20, 12'h000, 3'b000);
        collect("delay_off");
        do_ack("delay_off");

        // Saturation: 20 coincidences into a 4-bit counter.
        for (int i = 0; i < 20; i++) begin add_word(3'b011); add_idle(1); end
        launch(12'h000, 0, 60, 12'h00F, 3'b001);
        collect("saturate");
        do_ack("saturate");

        // Seven coincidences, then an aborted run leaves the snapshot intact.
        for (int i = 0; i < 7; i++) begin add_word(3'b011); add_idle(1); end
        launch(12'h000, 0, 30, 12'h007, 3'b000);
        collect("seven");
        do_ack("seven");
        GateLen = 8'd30;
        Start   = 1'b1;
        tick();
        Start   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            Channels = 3'b011; tick();
            Channels = 3'b000; tick();
        end
        Abort = 1'b1;
        tick();
        Abort = 1'b0;
        check("abort_busy", 32'(Busy), 32'd0);
        check("abort_valid", 32'(Valid), 32'd0);
        check("abort_counts", 32'(Counts), 32'h007);
        repeat (40) tick();
        check("abort_no_valid_later", 32'(Valid), 32'd0);

        // GateLen of zero runs for a single cycle.
        launch(12'h000, 0, 0, 12'h000, 3'b000);
        collect("gate_zero");
        do_ack("gate_zero");

        // Start while DONE drops Valid and begins a new run.
        launch(12'h000, 0, 10, 12'h000, 3'b000);
        collect("pre_restart");
        add_idle(3); add_word(3'b110);
        launch(12'h000, 0, 15, 12'h100, 3'b000);
        collect("restart");

        // Asynchronous reset in the middle of a run.
        Ack = 1'b1; tick(); Ack = 1'b0;
        GateLen = 8'd50;
        Start   = 1'b1;
        tick();
        Start   = 1'b0;
        repeat (5) tick();
        @(posedge Clk);
        #3;
        Rst_n = 1'b0;
        #1;
        check("async_rst_busy", 32'(Busy), 32'd0);
        check("async_rst_valid", 32'(Valid), 32'd0);
        check("async_rst_counts", 32'(Counts), 32'd0);
        check("async_rst_overflow", 32'(Overflow), 32'd0);
        repeat (2) tick();
        Rst_n = 1'b1;
        tick();
        for (int i = 0; i < 15; i++) begin
            Channels = 3'b111; tick();
            Channels = 3'b000; tick();
        end
        check("no_start_valid", 32'(Valid), 32'd0);
        check("no_start_busy", 32'(Busy), 32'd0);
        check("no_start_counts", 32'(Counts), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
